line_shift_ctrl: RTL and testbench

LINE_SHIFT_CTRL -- requirements
Module: line_shift_ctrl

---
 rtl/line_shift_ctrl.sv | 80 ++++++++
 tb/tb_line_shift_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/line_shift_ctrl.sv
// line_shift_ctrl: sequences a RAM-based one-line shift buffer for a pixel stream,
// aligning the previous-line tap with the current pixel and tracking row/column.
module line_shift_ctrl #(
  parameter int DSIZE  = 8,
  parameter int WDEPTH = 800,
  parameter int ASIZE  = $clog2(WDEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ASIZE:0]   cfg_width,
  input  logic             vsync_i,
  input  logic             de_i,
  input  logic [DSIZE-1:0] din_i,
  output logic [ASIZE-1:0] ram_raddr,
  output logic             ram_we,
  output logic [ASIZE-1:0] ram_waddr,
  output logic [DSIZE-1:0] ram_wdata,
  output logic             sclr,
  output logic             dout_valid,
  output logic [DSIZE-1:0] cur_pix,
  output logic [ASIZE-1:0] col_cnt,
  output logic [11:0]      row_cnt,
  output logic [1:0]       bayer_phase,
  output logic             line_done,
  output logic             frame_err
);
  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;
  state_t state, state_nx;
  logic vsync_q, vs_edge, acc, last;
  logic [ASIZE:0] width, width_clamp;
  assign vs_edge = vsync_i & ~vsync_q;
  assign acc = de_i & (state != IDLE) & ~vs_edge;
  assign last = ({1'b0, col_cnt} == width - 1'b1);
  assign ram_raddr = col_cnt;
  assign width_clamp = (cfg_width < (ASIZE+1)'(2)) ? (ASIZE+1)'(2) :
                       (cfg_width > (ASIZE+1)'(WDEPTH)) ? (ASIZE+1)'(WDEPTH) : cfg_width;
  always_comb begin
    state_nx = state;
    if (vs_edge) state_nx = FILL;
    else if (state == FILL && acc && last) state_nx = RUN;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      vsync_q     <= 1'b0;
      width       <= '0;
      col_cnt     <= '0;
      row_cnt     <= '0;
      sclr        <= 1'b0;
      frame_err   <= 1'b0;
      ram_we      <= 1'b0;
      ram_waddr   <= '0;
      ram_wdata   <= '0;
      line_done   <= 1'b0;
      dout_valid  <= 1'b0;
      cur_pix     <= '0;
      bayer_phase <= '0;
    end else begin
      state       <= state_nx;
      vsync_q     <= vsync_i;
      sclr        <= vs_edge;
      ram_we      <= acc;
      ram_waddr   <= col_cnt;
      ram_wdata   <= din_i;
      line_done   <= acc & last;
      dout_valid  <= acc & (state == RUN);
      cur_pix     <= din_i;
      bayer_phase <= {row_cnt[0], col_cnt[0]};
      if (vs_edge) begin
        width   <= width_clamp;
        col_cnt <= '0;
        row_cnt <= '0;
        if (col_cnt != '0) frame_err <= 1'b1;
      end else if (acc) begin
        col_cnt <= last ? '0 : col_cnt + 1'b1;
        if (last && row_cnt != 12'hfff) row_cnt <= row_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_line_shift_ctrl.sv
// tb_line_shift_ctrl: table vectors plus a behavioural model and scoreboard for line_shift_ctrl.
module tb_line_shift_ctrl;
  logic clk = 0, rst_n = 0;
  logic [10:0] cfg_width = 11'd4;
  logic vsync_i = 0, de_i = 0;
  logic [7:0] din_i = 0;
  logic [9:0] ram_raddr, ram_waddr, col_cnt;
  logic ram_we, sclr, dout_valid, line_done, frame_err;
  logic [7:0] ram_wdata, cur_pix, ram_q;
  logic [11:0] row_cnt;
  logic [1:0] bayer_phase;
  logic [7:0] mem [800];
  int tests = 0, fails = 0, nv = 0, ns = 0;
  int m_state = 0, m_col = 0, m_row = 0, m_width = 2;
  logic m_err = 0, m_vs = 0;
  logic [7:0] m_line [800];
  typedef struct {logic [7:0] pix; logic [7:0] tap; logic [1:0] ph;} exp_t;
  exp_t sb[$];
  typedef struct {logic v; logic de; logic [7:0] d; int col; int row; logic ld;} vec_t;
  vec_t tbl [16];

  line_shift_ctrl dut (.clk(clk), .rst_n(rst_n), .cfg_width(cfg_width), .vsync_i(vsync_i),
    .de_i(de_i), .din_i(din_i), .ram_raddr(ram_raddr), .ram_we(ram_we), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata), .sclr(sclr), .dout_valid(dout_valid), .cur_pix(cur_pix),
    .col_cnt(col_cnt), .row_cnt(row_cnt), .bayer_phase(bayer_phase), .line_done(line_done),
    .frame_err(frame_err));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_q <= mem[ram_raddr];
  end

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endfunction

  function automatic int clampw(int w);
    return w < 2 ? 2 : (w > 800 ? 800 : w);
  endfunction

  task automatic cyc(input logic v, input logic de, input logic [7:0] d);
    logic edg, acc, last, run;
    int c;
    exp_t e;
    vsync_i = v; de_i = de; din_i = d;
    #1;
    edg = v & ~m_vs;
    acc = de && m_state != 0 && !edg;
    run = (m_state == 2);
    last = (m_col == m_width - 1);
    c = m_col;
    if (de && m_state != 0) chk("raddr", 32'(ram_raddr), m_col);
    if (acc && run) begin
      e.pix = d; e.tap = m_line[m_col]; e.ph = {m_row[0], m_col[0]};
      sb.push_back(e);
    end
    if (edg) begin
      if (m_col != 0) m_err = 1;
      m_width = clampw(int'(cfg_width)); m_col = 0; m_row = 0; m_state = 1;
    end else if (acc) begin
      m_line[m_col] = d;
      if (last) begin
        m_col = 0;
        if (m_row != 4095) m_row++;
        if (m_state == 1) m_state = 2;
      end else m_col++;
    end
    m_vs = v;
    @(posedge clk); #1;
    chk("sclr", 32'(sclr), 32'(edg));
    chk("line_done", 32'(line_done), 32'(acc && last));
    chk("ram_we", 32'(ram_we), 32'(acc));
    if (acc) begin
      chk("waddr", 32'(ram_waddr), c);
      chk("wdata", 32'(ram_wdata), 32'(d));
    end
    chk("col_cnt", 32'(col_cnt), m_col);
    chk("row_cnt", 32'(row_cnt), m_row);
    chk("frame_err", 32'(frame_err), 32'(m_err));
    chk("dout_valid", 32'(dout_valid), 32'(acc && run));
    if (sclr) ns++;
    if (dout_valid) begin
      nv++;
      if (sb.size() == 0) chk("sb_empty", 1, 0);
      else begin
        e = sb.pop_front();
        chk("cur_pix", 32'(cur_pix), 32'(e.pix));
        chk("ram_tap", 32'(ram_q), 32'(e.tap));
        chk("bayer", 32'(bayer_phase), 32'(e.ph));
      end
    end
  endtask

  task automatic zero_check(string n);
    chk({n, "_outs"}, {ram_raddr, ram_we, ram_waddr, sclr, dout_valid, line_done, frame_err}, 0);
    chk({n, "_data"}, {ram_wdata, cur_pix, bayer_phase}, 0);
    chk({n, "_cnt"}, {col_cnt, row_cnt}, 0);
  endtask

  task automatic frame(input int w);
    cfg_width = 11'(w);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 8'd0, 0, 0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'd1, 1, 0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'd0, 1, 0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 8'd2, 2, 0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'd0, 2, 0, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 8'd3, 3, 0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 8'd0, 3, 0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 8'd4, 0, 1, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 8'd0, 0, 1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 8'd5, 1, 1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 8'd0, 1, 1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 8'd6, 2, 1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 8'd0, 2, 1, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 8'd7, 3, 1, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 8'd0, 3, 1, 1'b0};
    tbl[15] = '{1'b1, 1'b1, 8'd8, 0, 2, 1'b1};
    for (int i = 0; i < 800; i++) begin mem[i] = 0; m_line[i] = 0; end
    #3 zero_check("reset");
    @(posedge clk); #1 rst_n = 1;
    cyc(0, 1, 8'h55);
    cyc(0, 1, 8'h56);
    // gapped pixels, width 4
    cfg_width = 4;
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].v, tbl[i].de, tbl[i].d);
      chk("t_col", 32'(col_cnt), tbl[i].col);
      chk("t_row", 32'(row_cnt), tbl[i].row);
      chk("t_ld", 32'(line_done), 32'(tbl[i].ld));
    end
    // 12 back-to-back pixels
    ns = 0; nv = 0;
    frame(4);
    for (int i = 1; i <= 12; i++) cyc(1, 1, 8'(i));
    chk("s42_sclr", ns, 1);
    chk("s42_valid", nv, 8);
    chk("s42_row", 32'(row_cnt), 3);
    // frame restarted mid-line
    frame(4);
    cyc(1, 1, 8'd20); cyc(1, 1, 8'd21);
    frame(4);
    chk("s44_err", 32'(frame_err), 1);
    for (int i = 0; i < 4; i++) cyc(1, 1, 8'(30 + i));
    frame(4);
    chk("s44_sticky", 32'(frame_err), 1);
    // async reset mid row 1
    for (int i = 0; i < 6; i++) cyc(1, 1, 8'(40 + i));
    vsync_i = 0; de_i = 1;
    rst_n = 0;
    #1 zero_check("async_rst");
    m_state = 0; m_col = 0; m_row = 0; m_err = 0; m_vs = 0; sb.delete();
    @(posedge clk); #1 zero_check("hold_rst");
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 8'(50 + i));
      chk("no_write", 32'(ram_we), 0);
    end
    // clamp high, with a mid-frame cfg change that must not apply
    frame(1000);
    cfg_width = 4;
    for (int i = 0; i < 800; i++) cyc(1, 1, 8'(i * 7));
    chk("clamp_hi_row", 32'(row_cnt), 1);
    frame(0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 8'(i + 100));
    chk("clamp_lo_row", 32'(row_cnt), 2);
    // full-width two lines
    nv = 0;
    frame(800);
    for (int i = 0; i < 1600; i++) cyc(1, (i % 97) != 96 || 1'b1, 8'(i * 3 + 1));
    chk("s45_row", 32'(row_cnt), 2);
    chk("s45_valid", nv, 800);
    // row counter saturation
    frame(2);
    for (int i = 0; i < 8194; i++) cyc(1, 1, 8'(i));
    chk("row_sat", 32'(row_cnt), 4095);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
